// File: rtl/sprite_pkg.sv
// Shared definitions for the sprite fetch path: requester IDs and pixel word layout.
package sprite_pkg;

    typedef logic [1:0] req_id_t;

    localparam req_id_t REQ_DUCK = 2'd0;
    localparam req_id_t REQ_DOG  = 2'd1;
    localparam req_id_t REQ_BG   = 2'd2;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

endpackage

// File: rtl/rr_pick.sv
// Round-robin pick: first active request at or after ptr, as one-hot plus index.
module rr_pick #(
    parameter int N_REQ = 3,
    parameter int ID_W  = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [ID_W-1:0]  idx
);

    // Walk the requesters in rotated order starting at ptr; the first hit wins.
    always_comb begin
        int  j;
        logic found;
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 0; k < N_REQ; k++) begin
            j = int'(ptr) + k;
            if (j >= N_REQ) begin
                j = j - N_REQ;
            end
            if (!found && req[j]) begin
                found  = 1'b1;
                gnt[j] = 1'b1;
                idx    = ID_W'(j);
            end
        end
    end

endmodule

// File: rtl/sprite_fetch_arbiter.sv
// Shares one sprite ROM read port between the sprite address generators, round-robin,
// and returns each read's data tagged with the requester ID after the ROM latency.
module sprite_fetch_arbiter
    import sprite_pkg::*;
#(
    parameter int N_REQ  = 3,
    parameter int ADDR_W = 16,
    parameter int DATA_W = 24,
    parameter int RD_LAT = 2,
    localparam int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic                    frame_start,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*ADDR_W-1:0] req_addr,
    output logic [N_REQ-1:0]        gnt,
    output logic                    rom_rd,
    output logic [ADDR_W-1:0]       rom_addr,
    input  logic [DATA_W-1:0]       rom_data,
    output logic                    rd_valid,
    output logic [ID_W-1:0]         rd_id,
    output logic [DATA_W-1:0]       rd_data
);

    logic [ID_W-1:0]   ptr;
    logic [ID_W-1:0]   gnt_idx;
    logic [RD_LAT-1:0] tag_valid;
    logic [ID_W-1:0]   tag_id [RD_LAT];

    rr_pick #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_pick (
        .req (req),
        .ptr (ptr),
        .gnt (gnt),
        .idx (gnt_idx)
    );

    always_comb begin
        rom_rd   = |gnt;
        rom_addr = '0;
        if (rom_rd) begin
            rom_addr = req_addr[gnt_idx*ADDR_W +: ADDR_W];
        end
    end

    // frame_start wins over the grant update so every frame starts at the duck.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            ptr <= '0;
        end else if (frame_start) begin
            ptr <= '0;
        end else if (rom_rd) begin
            if (gnt_idx == ID_W'(N_REQ - 1)) begin
                ptr <= '0;
            end else begin
                ptr <= gnt_idx + 1'b1;
            end
        end
    end

    // Tag shift register tracks each read through the ROM latency; frame_start leaves it alone.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            tag_valid <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                tag_id[i] <= '0;
            end
        end else begin
            tag_valid[0] <= rom_rd;
            tag_id[0]    <= gnt_idx;
            for (int i = 1; i < RD_LAT; i++) begin
                tag_valid[i] <= tag_valid[i-1];
                tag_id[i]    <= tag_id[i-1];
            end
        end
    end

    assign rd_valid = tag_valid[RD_LAT-1];
    assign rd_id    = tag_id[RD_LAT-1];
    assign rd_data  = rom_data;

endmodule

// File: tb/tb_sprite_fetch_arbiter.sv
// Directed bench for sprite_fetch_arbiter with a 2-cycle ROM model.
module tb_sprite_fetch_arbiter;

    logic        Clk;
    logic        Reset;
    logic        frame_start;
    logic [2:0]  req;
    logic [47:0] req_addr;
    logic [2:0]  gnt;
    logic        rom_rd;
    logic [15:0] rom_addr;
    logic [23:0] rom_data;
    logic        rd_valid;
    logic [1:0]  rd_id;
    logic [23:0] rd_data;

    logic [23:0] rom_q1;
    logic [23:0] rom_q2;

    int vectors;
    int miscompares;
    int cyc;

    sprite_fetch_arbiter #(
        .N_REQ  (3),
        .ADDR_W (16),
        .DATA_W (24),
        .RD_LAT (2)
    ) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .frame_start (frame_start),
        .req         (req),
        .req_addr    (req_addr),
        .gnt         (gnt),
        .rom_rd      (rom_rd),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .rd_valid    (rd_valid),
        .rd_id       (rd_id),
        .rd_data     (rd_data)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic logic [23:0] rom_word(input logic [15:0] a);
        return {a[7:0] ^ 8'h5A, a};
    endfunction

    // Two-register synchronous ROM: address in cycle t, data in cycle t+2.
    initial begin
        rom_q1 = '0;
        rom_q2 = '0;
    end
    always @(posedge Clk) begin
        rom_q1 <= rom_rd ? rom_word(rom_addr) : 24'h0;
        rom_q2 <= rom_q1;
    end
    assign rom_data = rom_q2;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(
        input logic [2:0]  r,
        input logic [47:0] a,
        input logic        fs,
        input logic        rst,
        input logic [2:0]  exp_gnt,
        input logic [15:0] exp_addr,
        input logic        exp_valid,
        input logic [1:0]  exp_id,
        input logic [15:0] exp_data_addr
    );
        @(negedge Clk);
        req         = r;
        req_addr    = a;
        frame_start = fs;
        Reset       = rst;
        #1;
        checkOutput($sformatf("c%0d gnt", cyc), 32'(gnt), 32'(exp_gnt));
        checkOutput($sformatf("c%0d rom_rd", cyc), 32'(rom_rd), 32'(exp_gnt != 3'b000));
        checkOutput($sformatf("c%0d rom_addr", cyc), 32'(rom_addr), 32'(exp_addr));
        checkOutput($sformatf("c%0d rd_valid", cyc), 32'(rd_valid), 32'(exp_valid));
        if (exp_valid) begin
            checkOutput($sformatf("c%0d rd_id", cyc), 32'(rd_id), 32'(exp_id));
            checkOutput($sformatf("c%0d rd_data", cyc), 32'(rd_data), 32'(rom_word(exp_data_addr)));
        end
        cyc++;
    endtask

    localparam logic [47:0] ALL3 = {16'h0300, 16'h0200, 16'h0100};

    initial begin
        vectors     = 0;
        miscompares = 0;
        cyc         = 0;
        Reset       = 1'b1;
        frame_start = 1'b0;
        req         = '0;
        req_addr    = '0;

        // reset state
        applyStimulus(3'b000, 48'h0, 1'b0, 1'b1, 3'b000, 16'h0, 1'b0, 2'd0, 16'h0);
        checkOutput("reset rd_id", 32'(rd_id), 32'd0);

        // single requester, back-to-back addresses
        applyStimulus(3'b001, {32'h0, 16'h0010}, 1'b0, 1'b0, 3'b001, 16'h0010, 1'b0, 2'd0, 16'h0);
        applyStimulus(3'b001, {32'h0, 16'h0011}, 1'b0, 1'b0, 3'b001, 16'h0011, 1'b0, 2'd0, 16'h0);
        applyStimulus(3'b000, 48'h0, 1'b0, 1'b0, 3'b000, 16'h0, 1'b1, 2'd0, 16'h0010);
        applyStimulus(3'b000, 48'h0, 1'b0, 1'b0, 3'b000, 16'h0, 1'b1, 2'd0, 16'h0011);
        // ptr is 1 here; an idle frame_start brings it back to 0
        applyStimulus(3'b000, 48'h0, 1'b1, 1'b0, 3'b000, 16'h0, 1'b0, 2'd0, 16'h0);

        // all requesters continuous from ptr = 0
        applyStimulus(3'b111, ALL3, 1'b0, 1'b0, 3'b001, 16'h0100, 1'b0, 2'd0, 16'h0);
        applyStimulus(3'b111, ALL3, 1'b0, 1'b0, 3'b010, 16'h0200, 1'b0, 2'd0, 16'h0);
        applyStimulus(3'b111, ALL3, 1'b0, 1'b0, 3'b100, 16'h0300, 1'b1, 2'd0, 16'h0100);
        applyStimulus(3'b111, ALL3, 1'b0, 1'b0, 3'b001, 16'h0100, 1'b1, 2'd1, 16'h0200);

        // req = 101 with ptr = 1: requesters 2 and 0 alternate
        applyStimulus(3'b101, ALL3, 1'b0, 1'b0, 3'b100, 16'h0300, 1'b1, 2'd2, 16'h0300);
        applyStimulus(3'b101, ALL3, 1'b0, 1'b0, 3'b001, 16'h0100, 1'b1, 2'd0, 16'h0100);
        applyStimulus(3'b101, ALL3, 1'b0, 1'b0, 3'b100, 16'h0300, 1'b1, 2'd2, 16'h0300);
        applyStimulus(3'b101, ALL3, 1'b0, 1'b0, 3'b001, 16'h0100, 1'b1, 2'd0, 16'h0100);

        // frame_start with a grant to 1: next grant goes to 0, not 2
        applyStimulus(3'b111, ALL3, 1'b1, 1'b0, 3'b010, 16'h0200, 1'b1, 2'd2, 16'h0300);
        applyStimulus(3'b111, ALL3, 1'b0, 1'b0, 3'b001, 16'h0100, 1'b1, 2'd0, 16'h0100);
        applyStimulus(3'b111, ALL3, 1'b0, 1'b0, 3'b010, 16'h0200, 1'b1, 2'd1, 16'h0200);
        applyStimulus(3'b111, ALL3, 1'b0, 1'b0, 3'b100, 16'h0300, 1'b1, 2'd0, 16'h0100);

        // reset after two back-to-back grants; grant during reset uses ptr = 0
        applyStimulus(3'b111, ALL3, 1'b0, 1'b0, 3'b001, 16'h0100, 1'b1, 2'd1, 16'h0200);
        applyStimulus(3'b111, ALL3, 1'b0, 1'b0, 3'b010, 16'h0200, 1'b1, 2'd2, 16'h0300);
        applyStimulus(3'b110, ALL3, 1'b0, 1'b1, 3'b010, 16'h0200, 1'b0, 2'd0, 16'h0);
        applyStimulus(3'b000, 48'h0, 1'b0, 1'b0, 3'b000, 16'h0, 1'b0, 2'd0, 16'h0);
        applyStimulus(3'b000, 48'h0, 1'b0, 1'b0, 3'b000, 16'h0, 1'b0, 2'd0, 16'h0);
        applyStimulus(3'b110, ALL3, 1'b0, 1'b0, 3'b010, 16'h0200, 1'b0, 2'd0, 16'h0);

        // idle for 5 cycles: ptr holds at 2
        applyStimulus(3'b000, 48'h0, 1'b0, 1'b0, 3'b000, 16'h0, 1'b0, 2'd0, 16'h0);
        applyStimulus(3'b000, 48'h0, 1'b0, 1'b0, 3'b000, 16'h0, 1'b1, 2'd1, 16'h0200);
        applyStimulus(3'b000, 48'h0, 1'b0, 1'b0, 3'b000, 16'h0, 1'b0, 2'd0, 16'h0);
        applyStimulus(3'b000, 48'h0, 1'b0, 1'b0, 3'b000, 16'h0, 1'b0, 2'd0, 16'h0);
        applyStimulus(3'b000, 48'h0, 1'b0, 1'b0, 3'b000, 16'h0, 1'b0, 2'd0, 16'h0);
        applyStimulus(3'b111, ALL3, 1'b0, 1'b0, 3'b100, 16'h0300, 1'b0, 2'd0, 16'h0);
        applyStimulus(3'b000, 48'h0, 1'b0, 1'b0, 3'b000, 16'h0, 1'b0, 2'd0, 16'h0);
        applyStimulus(3'b000, 48'h0, 1'b0, 1'b0, 3'b000, 16'h0, 1'b1, 2'd2, 16'h0300);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sprite_fetch_arbiter.md
# sprite_fetch_arbiter

Shares one synchronous sprite ROM read port between the per-pixel sprite address generators: the duck, the dog and the background/crosshair layer. Each cycle it grants at most one requester, round-robin, and drives that requester's address into the ROM. It tags each read and returns the data with the requester ID after the fixed ROM latency. It sits between the sprite movement blocks and `color_mapper`, replacing one ROM per sprite with a single shared ROM.

## Interface
Parameters:
- `N_REQ`, 3: number of requesters (0 = duck, 1 = dog, 2 = background).
- `ADDR_W`, 16: ROM address width; narrower requester addresses are zero-extended by the instantiator.
- `DATA_W`, 24: ROM word width (8-bit R, G, B).
- `RD_LAT`, 2: ROM read latency in cycles, address to data; must be ≥ 1.

Ports:
- `Clk` in 1: system clock, 50 MHz.
- `Reset` in 1: asynchronous, active-high reset.
- `frame_start` in 1: one-cycle pulse at the start of each frame, derived from `VGA_VS`.
- `req` in N_REQ: per-requester read request, level.
- `req_addr` in N_REQ×ADDR_W: per-requester address, packed with requester i at bits [i*ADDR_W +: ADDR_W].
- `gnt` out N_REQ: one-hot grant, combinational, same cycle as `req`.
- `rom_rd` out 1: ROM read enable.
- `rom_addr` out ADDR_W: ROM address.
- `rom_data` in DATA_W: ROM read data, valid RD_LAT cycles after `rom_rd`.
- `rd_valid` out 1: returned data valid.
- `rd_id` out clog2(N_REQ): requester ID of the returned data.
- `rd_data` out DATA_W: returned data; equals `rom_data` whenever `rd_valid` is high.

## Operation
- Round-robin pointer `ptr` holds the highest-priority requester. Starting at `ptr`, the first i with `req[i]` = 1 is granted.
- A request is accepted in the cycle its `gnt` bit is high. The requester then presents its next address or drops `req`. There is no other handshake.
- Pointer update:
  - After a grant to i, `ptr` becomes (i+1) mod N_REQ.
  - With no request, `ptr` holds.
  - `frame_start` forces `ptr` to 0. It overrides a same-cycle grant update so that pixel ordering is identical in every frame.
- In a cycle with a grant:
  - `rom_rd` = 1 and `rom_addr` = address of the granted requester.
  - Otherwise `rom_rd` = 0 and `rom_addr` = 0.
- Tag pipeline: a shift register RD_LAT deep of {valid, id}. Stage 0 loads {`rom_rd`, granted id}. The last stage drives `rd_valid`/`rd_id`.
- The arbiter never stalls. Issue rate is one read per cycle.
- `frame_start` does not flush the tag pipeline; in-flight reads complete.

## Timing
- Grant latency is 0 cycles: `gnt` and `rom_addr` are combinational from `req`, `req_addr` and `ptr`.
- Read latency: a grant in cycle t produces `rd_valid` = 1 with the matching `rd_id` in cycle t+RD_LAT.
- Reset values:
  - `ptr` = 0 and all tag stages invalid.
  - `gnt` = 0 only while `req` = 0. During reset, `gnt` still follows `req` with `ptr` = 0.
  - `rom_rd` follows `gnt`.
  - `rd_valid` = 0, `rd_id` = 0.
  - `rd_data` is a passthrough and is undefined when not valid.
- Reset mid-operation: all in-flight tags are discarded immediately (asynchronous). No `rd_valid` appears for reads issued before or during reset.
- With all requesters active continuously, each is served exactly once every N_REQ cycles. Worst-case wait is N_REQ−1 cycles.
- A single active requester is granted every cycle.
- `ptr` wraps from N_REQ−1 to 0.

## Structure
- Shared package `sprite_pkg`:
  - requester ID constants `REQ_DUCK` = 0, `REQ_DOG` = 1, `REQ_BG` = 2;
  - typedef `req_id_t` (2 bits);
  - typedef `rgb_t` (24-bit packed R, G, B).
- Sub-module `rr_pick`: combinational rotate, priority-encode and un-rotate. Inputs are `req` and `ptr`; outputs are the one-hot grant and the index.
- The tag pipeline and the pointer register live in the top module.

## Test plan
- Reset then single requester: `req` = 3'b001 with addr 0x0010, 0x0011 on successive cycles → `gnt` = 001 every cycle, `rom_addr` 0x0010 then 0x0011, `rd_valid` with `rd_id` = 0 at cycles +2, +3.
- All requesters continuous, `ptr` = 0 → grant sequence 001, 010, 100, 001 …; `rd_id` sequence 0, 1, 2, 0 delayed 2 cycles; `rd_data` matches a ROM model at each address.
- `req` = 3'b101 after a grant to 0 (`ptr` = 1) → requester 2 granted, then requester 0, alternating; requester 1 is never granted.
- `frame_start` in the same cycle as a grant to 1 → next cycle `ptr` = 0. With all requesters active, requester 0 is granted, not requester 2.
- `Reset` asserted 1 cycle after two back-to-back grants, for 1 cycle → no `rd_valid` in the following 3 cycles, `ptr` = 0 afterwards.
- `req` = 0 for 5 cycles → `rom_rd` = 0 and `gnt` = 0 throughout, `ptr` unchanged, `rd_valid` = 0 from cycle +2 onward.
